// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 2604;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period timer owned by the RX controller; flags the mid-start-bit and
// full-bit-period points relative to the last clear.
module uart_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic half_hit,
    output logic full_hit
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign half_hit = (r_count == HALF_LAST);
    assign full_hit = (r_count == FULL_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes rxd, frames start/data/stop bits and
// presents each good byte on a single-entry valid/ready holding register.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_en,
    input  logic                   rxd,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   busy
);

    logic                   r_sync1;
    logic                   r_rxd_s;
    logic                   r_rxd_prev;
    uart_rx_state_t         r_state;
    logic [UART_DATA_W-1:0] r_shift;
    logic [2:0]             r_bit_idx;
    logic [UART_DATA_W-1:0] r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic w_fall;
    logic w_accept;
    logic w_half_hit;
    logic w_full_hit;
    logic w_timer_clr;
    logic w_timer_en;

    // Sync flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync1    <= rxd;
            r_rxd_s    <= r_sync1;
            r_rxd_prev <= r_rxd_s;
        end
    end

    assign w_fall   = r_rxd_prev & ~r_rxd_s;
    assign w_accept = r_rx_valid & rx_ready;

    assign w_timer_en  = (r_state != IDLE);
    assign w_timer_clr = !rx_en
                       || (r_state == IDLE)
                       || ((r_state == START) && w_half_hit)
                       || (((r_state == DATA) || (r_state == STOP)) && w_full_hit);

    uart_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_timer_clr),
        .en       (w_timer_en),
        .half_hit (w_half_hit),
        .full_hit (w_full_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (w_accept) begin
                r_rx_valid <= 1'b0;
            end

            if (!rx_en) begin
                r_state   <= IDLE;
                r_shift   <= '0;
                r_bit_idx <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_fall) begin
                            r_state <= START;
                        end
                    end
                    START: begin
                        if (w_half_hit) begin
                            if (r_rxd_s) begin
                                r_state <= IDLE;
                            end else begin
                                r_state   <= DATA;
                                r_bit_idx <= '0;
                            end
                        end
                    end
                    DATA: begin
                        if (w_full_hit) begin
                            r_shift <= {r_rxd_s, r_shift[UART_DATA_W-1:1]};
                            if (r_bit_idx == 3'(UART_DATA_W - 1)) begin
                                r_state <= STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        if (w_full_hit) begin
                            r_state <= IDLE;
                            // A same-cycle accept frees the holding register for the new byte.
                            if (r_rxd_s) begin
                                if (!r_rx_valid || rx_ready) begin
                                    r_rx_data  <= r_shift;
                                    r_rx_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl at 16 clocks per bit.
module tb_uart_rx_ctrl;

    localparam int CPB        = 16;
    localparam int PULSE_FERR = 1;
    localparam int PULSE_OVR  = 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_en    = 1'b0;
    logic       rxd      = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors     = 0;
    int checks     = 0;
    int cycle      = 0;
    int edgeCycle  = 0;
    int riseCycle  = 0;
    int validWidth = 0;
    int busyCount  = 0;
    logic prevValid = 1'b0;

    logic [7:0] byteQ[$];
    int         pulseQ[$];

    uart_rx_ctrl #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_en     (rx_en),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one full frame on the pad starting now; returns with the line high.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        edgeCycle = cycle;
        rxd = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            waitCycles(CPB);
        end
        rxd = stopBit;
        waitCycles(CPB);
        rxd = 1'b1;
    endtask

    // Monitor: pops expected pulses and accepted bytes as the DUT presents them.
    always @(negedge clk) begin : monitor
        int actKind;
        int expKind;
        logic [7:0] expByte;
        if (rx_valid === 1'b1 && prevValid !== 1'b1) begin
            riseCycle  = cycle;
            validWidth = 1;
        end else if (rx_valid === 1'b1) begin
            validWidth++;
        end
        prevValid = rx_valid;
        if (busy === 1'b1) busyCount++;

        if (frame_err === 1'b1 || overrun === 1'b1) begin
            actKind = (frame_err === 1'b1) ? PULSE_FERR : PULSE_OVR;
            if (pulseQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected pulse: frame_err=%0b overrun=%0b, expected none",
                         frame_err, overrun);
            end else begin
                expKind = pulseQ.pop_front();
                checkOutput("pulse kind", actKind, expKind);
            end
        end

        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (byteQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected byte: got 0x%0h, expected none", rx_data);
            end else begin
                expByte = byteQ.pop_front();
                checkOutput("accepted byte", int'(rx_data), int'(expByte));
            end
        end
    end

    initial begin
        waitCycles(3);
        checkOutput("reset rx_data", int'(rx_data), 0);
        checkOutput("reset rx_valid", int'(rx_valid), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset frame_err", int'(frame_err), 0);
        checkOutput("reset overrun", int'(overrun), 0);
        rst_n = 1'b1;
        rx_en = 1'b1;
        waitCycles(4);

        // Good frame, consumer always ready
        rx_ready = 1'b1;
        byteQ.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1);
        waitCycles(8);
        checkOutput("A5 latency", riseCycle - edgeCycle, 2 + 8 + 9 * CPB + 1);
        checkOutput("A5 valid width", validWidth, 1);

        // Short low glitch: false start
        busyCount = 0;
        rxd = 1'b0;
        waitCycles(5);
        rxd = 1'b1;
        waitCycles(30);
        checkOutput("glitch busy cycles", busyCount, 8);
        checkOutput("glitch rx_valid", int'(rx_valid), 0);

        // Framing error, then a clean frame
        pulseQ.push_back(PULSE_FERR);
        applyStimulus(8'h3C, 1'b0);
        waitCycles(20);
        checkOutput("ferr rx_valid", int'(rx_valid), 0);
        byteQ.push_back(8'h81);
        applyStimulus(8'h81, 1'b1);
        waitCycles(8);

        // Back-to-back with consumer stalled: overrun
        rx_ready = 1'b0;
        byteQ.push_back(8'h11);
        applyStimulus(8'h11, 1'b1);
        pulseQ.push_back(PULSE_OVR);
        applyStimulus(8'h22, 1'b1);
        waitCycles(8);
        checkOutput("overrun keeps data", int'(rx_data), 8'h11);
        checkOutput("overrun keeps valid", int'(rx_valid), 1);
        rx_ready = 1'b1;
        waitCycles(1);
        rx_ready = 1'b0;
        waitCycles(2);

        // Back-to-back with accept in the delivery cycle: no overrun
        byteQ.push_back(8'h11);
        applyStimulus(8'h11, 1'b1);
        fork
            applyStimulus(8'h22, 1'b1);
            begin
                waitCycles(2 + 8 + 9 * CPB);
                rx_ready = 1'b1;
                waitCycles(1);
                rx_ready = 1'b0;
            end
        join
        waitCycles(8);
        checkOutput("delivery-accept rx_data", int'(rx_data), 8'h22);
        checkOutput("delivery-accept rx_valid", int'(rx_valid), 1);

        // Reset during data bit 3 drops the pending 0x22 and the frame
        fork
            applyStimulus(8'hF8, 1'b1);
            begin
                waitCycles(2 + 8 + 4 * CPB);
                rst_n = 1'b0;
                waitCycles(1);
                rst_n = 1'b1;
                checkOutput("midframe reset rx_data", int'(rx_data), 0);
                checkOutput("midframe reset rx_valid", int'(rx_valid), 0);
                checkOutput("midframe reset busy", int'(busy), 0);
                checkOutput("midframe reset frame_err", int'(frame_err), 0);
                checkOutput("midframe reset overrun", int'(overrun), 0);
            end
        join
        waitCycles(5);
        rx_ready = 1'b1;
        byteQ.push_back(8'h5A);
        applyStimulus(8'h5A, 1'b1);
        waitCycles(8);
        checkOutput("post-reset rx_data", int'(rx_data), 8'h5A);

        // rx_en drop mid-frame keeps the pending byte
        rx_ready = 1'b0;
        byteQ.push_back(8'h77);
        applyStimulus(8'h77, 1'b1);
        waitCycles(8);
        fork
            applyStimulus(8'h0F, 1'b1);
            begin
                waitCycles(2 + 8 + 4 * CPB);
                rx_en = 1'b0;
                waitCycles(1);
                checkOutput("rx_en drop busy", int'(busy), 0);
                checkOutput("rx_en drop rx_valid", int'(rx_valid), 1);
                checkOutput("rx_en drop rx_data", int'(rx_data), 8'h77);
            end
        join
        waitCycles(5);
        rx_ready = 1'b1;
        waitCycles(1);
        rx_ready = 1'b0;
        waitCycles(2);
        checkOutput("rx_en off accept clears valid", int'(rx_valid), 0);
        rx_en = 1'b1;

        waitCycles(10);
        checkOutput("byte queue drained", byteQ.size(), 0);
        checkOutput("pulse queue drained", pulseQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences bit timing for one serial input line. It detects the start bit, times the mid-bit sample points, shifts in 8 data bits LSB-first and checks the stop bit. Each good byte is presented on a single-entry valid/ready output. It sits between the `rxd` pad (via an internal synchronizer) and the byte consumer, and replaces a free-running RX baud tick with a controller-owned bit timer.

## Interface
- `CLKS_PER_BIT`, 2604, clk cycles per bit (50 MHz / 19200 baud); legal range 8..4095.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_en`  in  1  receiver enable; low forces IDLE.
- `rxd`  in  1  asynchronous serial input, idle high.
- `rx_data`  out  8  received byte, valid while `rx_valid`=1.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accepts byte when `rx_valid`&&`rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte completed while the holding register was full and not being accepted.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer (`rxd_s`), with sync flops reset to 1. Edge detect compares `rxd_s` with its previous value.
- HALF = CLKS_PER_BIT/2 (integer). Bit timer width = clog2(CLKS_PER_BIT+1).
- States:
  - IDLE: on a falling edge of `rxd_s` with `rx_en`=1, go to START and clear the timer.
  - START: at timer = HALF-1, sample `rxd_s`. If 1, the start is false: go to IDLE with no output. If 0, go to DATA with the timer cleared and bit index 0.
  - DATA: at timer = CLKS_PER_BIT-1, shift `rxd_s` into bit[index] (LSB first) and clear the timer. After index 7, go to STOP.
  - STOP: at timer = CLKS_PER_BIT-1, sample `rxd_s`. If 1, deliver the byte. If 0, pulse `frame_err` and discard the byte. Either way go to IDLE.
- Delivery:
  - If `rx_valid`=0, or `rx_valid`&&`rx_ready` in the same cycle, load `rx_data` and set `rx_valid`=1.
  - Otherwise pulse `overrun`, drop the new byte and keep the old one.
- `rx_valid` clears on accept unless a new byte loads in the same cycle.
- `rx_en`=0 in any state: next state IDLE, timer and shift register cleared. `rx_data`/`rx_valid` are retained and handshake still works.
- IDLE requires a fresh falling edge. A line held low after a framing error does not retrigger until it returns high.

## Timing
- Reset (`rst_n`=0 at a clk edge) sets: state IDLE, `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, timer 0, sync flops 1. Reset mid-frame abandons the frame with no pulse.
- Cycle T0 is the first cycle `rxd_s`=0 after 1, i.e. 2 cycles after the pad edge.
  - Start check: T0+HALF.
  - Data bit k (k = 0..7): T0+HALF+(k+1)·CLKS_PER_BIT.
  - Stop check: T0+HALF+9·CLKS_PER_BIT.
- `rx_valid`, `frame_err` and `overrun` update the cycle after the stop check. `busy` drops in that same cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package `uart_pkg`: state enum (IDLE, START, DATA, STOP), `UART_DATA_W`=8, default `CLKS_PER_BIT`.
- Sub-module `uart_rx_bit_timer`:
  - Inputs: `clk`, `rst_n`, `clr`, `en`.
  - Outputs: `half_hit`, `full_hit`.
  - Parameterised by CLKS_PER_BIT.
  - Controller FSM, synchronizer, shift register and holding register stay in `uart_rx_ctrl`.

## Test plan
All scenarios use CLKS_PER_BIT=16 for speed.
- Frame 0xA5 with good stop, `rx_ready`=1 → `rx_data`=0xA5 and `rx_valid` high for 1 cycle, 2+8+9·16+1 cycles after the pad edge; `frame_err`=`overrun`=0.
- Low glitch of 5 cycles on `rxd` → start check reads 1, back to IDLE, `busy` high for 8 cycles only, no output.
- Frame 0x3C with stop bit 0 → `frame_err` single pulse, `rx_valid` stays 0, next frame 0x81 received correctly after the line returns high.
- Two back-to-back frames 0x11, 0x22 with `rx_ready`=0 → `rx_data` stays 0x11, `overrun` pulses once. Repeat with `rx_ready` asserted in the delivery cycle → `rx_data`=0x22, no overrun.
- `rst_n` low for 1 cycle during DATA bit 3 → all outputs at reset values; the following 0x5A frame is received correctly.
- `rx_en` dropped during DATA with a pending byte 0x77 → state IDLE, `rx_valid`=1 with 0x77 preserved, accept works.
